// File: rtl/router_pkg.sv
// Shared constants for the router address/handshake controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents
//   NUM_PORTS  number of output FIFOs served by the controller
//   ADDR_W     width of the destination address field in the header byte
//   addr_t     destination address type
//   PORT0..2   address codes of the three output ports
//   ADDR_NONE  address code meaning "no destination latched"
package router_pkg;

   localparam int NUM_PORTS = 3;
   localparam int ADDR_W    = 2;

   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t PORT0     = 2'd0;
   localparam addr_t PORT1     = 2'd1;
   localparam addr_t PORT2     = 2'd2;
   localparam addr_t ADDR_NONE = 2'b11;

   // Default stall budget before a port's FIFO is cleared, and a counter
   // width able to hold TIMEOUT-1.
   localparam int TIMEOUT_DEF = 30;
   localparam int CNT_W_DEF   = 5;

   // True when the address selects one of the real output ports.
   function automatic logic addr_is_port(input addr_t a);
      return (a != ADDR_NONE);
   endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// Bundle of handshake/status signals between the router input FSM, the three
// output FIFOs, their consumers and the sync controller.
// Latency/backpressure: none of its own; the controller defines timing.
//
// Modports
//   slave   the sync controller: consumes FSM/FIFO/consumer signals,
//           drives write enables, the addressed full flag, valids and
//           per-port soft resets.
//   master  the surrounding environment (FSM, FIFOs, consumers).
interface router_sync_ctrl_if;
   import router_pkg::*;

   logic        detect_add;
   logic        pkt_valid;
   addr_t       data_in;
   logic        write_en_reg;
   logic        full_0;
   logic        full_1;
   logic        full_2;
   logic        empty_0;
   logic        empty_1;
   logic        empty_2;
   logic        read_enb_0;
   logic        read_enb_1;
   logic        read_enb_2;

   logic [NUM_PORTS-1:0] write_enb;
   logic        fifo_full;
   logic        vld_out_0;
   logic        vld_out_1;
   logic        vld_out_2;
   logic        soft_reset_0;
   logic        soft_reset_1;
   logic        soft_reset_2;

   modport slave (
      input  detect_add, pkt_valid, data_in, write_en_reg,
      input  full_0, full_1, full_2,
      input  empty_0, empty_1, empty_2,
      input  read_enb_0, read_enb_1, read_enb_2,
      output write_enb, fifo_full,
      output vld_out_0, vld_out_1, vld_out_2,
      output soft_reset_0, soft_reset_1, soft_reset_2
   );

   modport master (
      output detect_add, pkt_valid, data_in, write_en_reg,
      output full_0, full_1, full_2,
      output empty_0, empty_1, empty_2,
      output read_enb_0, read_enb_1, read_enb_2,
      input  write_enb, fifo_full,
      input  vld_out_0, vld_out_1, vld_out_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2
   );

endinterface

// File: rtl/router_timeout_cnt.sv
// Per-port consumer watchdog: pulses soft_reset when a valid FIFO goes unread.
// Latency: pulse is registered, high in the cycle after the TIMEOUT-th stall.
// Backpressure: none; a read or an empty FIFO simply restarts the count.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   vld         FIFO holds data
//   rd          consumer reads the FIFO this cycle
//   soft_reset  one-cycle clear pulse to the FIFO
//
// CNT_W must satisfy 2**CNT_W > TIMEOUT; the counter only ever holds
// values 0..TIMEOUT-1.
module router_timeout_cnt #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;
   logic             stall;

   // The pulse cycle itself is not a stall, so after a pulse the FIFO gets
   // a fresh full budget and the next pulse lands TIMEOUT+1 cycles later.
   assign stall = vld && !rd && !soft_reset;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end else if (stall) begin
         if (cnt == CNT_LAST) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
         end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
         end
      end else begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end
   end

endmodule

// File: rtl/router_sync_ctrl.sv
// Address/handshake controller between the router input FSM and three output FIFOs.
// Latency: address latched on the decode edge, used the next cycle; steering,
//          full mux and valids are combinational; soft resets are registered.
// Backpressure: the addressed FIFO's full flag is returned to the FSM as fifo_full.
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   router_sync_ctrl_if.slave:
//         in : detect_add, pkt_valid, data_in, write_en_reg,
//              full_0..2, empty_0..2, read_enb_0..2
//         out: write_enb[2:0] (one-hot), fifo_full, vld_out_0..2,
//              soft_reset_0..2
module router_sync_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   router_sync_ctrl_if.slave  bus
);

   addr_t                addr_q;
   logic [NUM_PORTS-1:0] vld;
   logic [NUM_PORTS-1:0] rd;
   logic [NUM_PORTS-1:0] soft_reset;

   // Destination address: captured only when the FSM is decoding a header
   // and the byte is valid; a stray detect_add mid-packet is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= ADDR_NONE;
      end else if (bus.detect_add && bus.pkt_valid) begin
         addr_q <= bus.data_in;
      end
   end

   // Write steering: at most one bit set; ADDR_NONE steers nowhere.
   always_comb begin
      bus.write_enb = '0;
      if (bus.write_en_reg && addr_is_port(addr_q)) begin
         case (addr_q)
            PORT0:   bus.write_enb = 3'b001;
            PORT1:   bus.write_enb = 3'b010;
            PORT2:   bus.write_enb = 3'b100;
            default: bus.write_enb = '0;
         endcase
      end
   end

   // Full flag of the addressed FIFO only; other ports' fullness is irrelevant.
   always_comb begin
      case (addr_q)
         PORT0:   bus.fifo_full = bus.full_0;
         PORT1:   bus.fifo_full = bus.full_1;
         PORT2:   bus.fifo_full = bus.full_2;
         default: bus.fifo_full = 1'b0;
      endcase
   end

   assign vld = {!bus.empty_2, !bus.empty_1, !bus.empty_0};
   assign rd  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

   assign bus.vld_out_0 = vld[0];
   assign bus.vld_out_1 = vld[1];
   assign bus.vld_out_2 = vld[2];

   // Soft resets are independent of write steering: a write and a clear to
   // the same FIFO in one cycle are both passed on, the FIFO arbitrates.
   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_tmo
      router_timeout_cnt #(
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_tmo (
         .clk        (clk),
         .rst        (rst),
         .vld        (vld[n]),
         .rd         (rd[n]),
         .soft_reset (soft_reset[n])
      );
   end

   assign bus.soft_reset_0 = soft_reset[0];
   assign bus.soft_reset_1 = soft_reset[1];
   assign bus.soft_reset_2 = soft_reset[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Self-checking bench for router_sync_ctrl: per-cycle scoreboard of expected
// outputs plus directed checks on address steering and timeout boundaries.
module tb_router_sync_ctrl;

   localparam int TMO = 30;

   typedef struct packed {
      logic [2:0] we;
      logic       ff;
      logic [2:0] vld;
      logic [2:0] sr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   router_sync_ctrl_if bus ();

   router_sync_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sbq[$];

   // Reference state
   int   m_addr;
   int   m_run [3];
   logic m_sr  [3];

   int   tick_no;
   int   pulses    [3];
   int   first_tick[3];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   function automatic logic [2:0] emp_v();
      return {bus.empty_2, bus.empty_1, bus.empty_0};
   endfunction

   function automatic logic [2:0] rd_v();
      return {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
   endfunction

   function automatic logic [2:0] full_v();
      return {bus.full_2, bus.full_1, bus.full_0};
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic [2:0] f;
      f    = full_v();
      e.we = 3'b000;
      e.ff = 1'b0;
      if (m_addr < 3) begin
         if (bus.write_en_reg) e.we[m_addr] = 1'b1;
         e.ff = f[m_addr];
      end
      e.vld = ~emp_v();
      e.sr  = {m_sr[2], m_sr[1], m_sr[0]};
      return e;
   endfunction

   task automatic model_reset();
      m_addr = 3;
      for (int n = 0; n < 3; n++) begin
         m_run[n] = 0;
         m_sr[n]  = 1'b0;
      end
   endtask

   task automatic clear_stats();
      tick_no = 0;
      for (int n = 0; n < 3; n++) begin
         pulses[n]     = 0;
         first_tick[n] = -1;
      end
   endtask

   task automatic compare_outs(input string tag, input exp_t e);
      chk({tag, "_we"},  {29'd0, bus.write_enb}, {29'd0, e.we});
      chk({tag, "_ff"},  {31'd0, bus.fifo_full}, {31'd0, e.ff});
      chk({tag, "_vld"}, {29'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, {29'd0, e.vld});
      chk({tag, "_sr"},  {29'd0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, {29'd0, e.sr});
   endtask

   // One clock: advance the reference with the inputs as driven, queue the
   // expected post-edge outputs, then compare once the DUT has clocked.
   task automatic tick(input string tag);
      logic [2:0] emp, rd, sr_obs;
      logic       nsr [3];
      exp_t       e;
      emp = emp_v();
      rd  = rd_v();
      for (int n = 0; n < 3; n++) begin
         nsr[n] = 1'b0;
         if (!emp[n] && !rd[n] && !m_sr[n]) begin
            m_run[n]++;
            if (m_run[n] == TMO) begin
               nsr[n]   = 1'b1;
               m_run[n] = 0;
            end
         end else begin
            m_run[n] = 0;
         end
      end
      for (int n = 0; n < 3; n++) m_sr[n] = nsr[n];
      if (bus.detect_add && bus.pkt_valid) m_addr = int'(bus.data_in);
      sbq.push_back(model_out());
      @(posedge clk);
      #1;
      tick_no++;
      e = sbq.pop_front();
      compare_outs(tag, e);
      sr_obs = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      for (int n = 0; n < 3; n++) begin
         if (sr_obs[n]) begin
            pulses[n]++;
            if (first_tick[n] < 0) first_tick[n] = tick_no;
         end
      end
   endtask

   task automatic settle(input string tag);
      #1;
      compare_outs(tag, model_out());
   endtask

   task automatic latch_addr(input logic [1:0] a);
      bus.detect_add = 1'b1;
      bus.pkt_valid  = 1'b1;
      bus.data_in    = a;
      tick("latch");
      bus.detect_add = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.detect_add   = 1'b0;
      bus.pkt_valid    = 1'b0;
      bus.data_in      = 2'd0;
      bus.write_en_reg = 1'b0;
      bus.full_0 = 1'b0; bus.full_1 = 1'b0; bus.full_2 = 1'b0;
      bus.empty_0 = 1'b1; bus.empty_1 = 1'b1; bus.empty_2 = 1'b1;
      bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
      model_reset();
      clear_stats();

      // 1. Reset state; valid follows empty even while in reset
      #12;
      settle("rst_idle");
      bus.empty_1      = 1'b0;
      bus.write_en_reg = 1'b1;
      bus.full_1       = 1'b1;
      settle("rst_vld");
      bus.empty_1      = 1'b1;
      bus.write_en_reg = 1'b0;
      bus.full_1       = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick("idle");

      // 2. Address 1 steering and full mux
      latch_addr(2'd1);
      bus.write_en_reg = 1'b1;
      settle("a1");
      chk("a1_we_dir", {29'd0, bus.write_enb}, 32'h2);
      bus.full_1 = 1'b1;
      settle("a1_full");
      chk("a1_ff_dir", {31'd0, bus.fifo_full}, 32'h1);
      for (int p = 0; p < 4; p++) begin
         bus.full_0 = p[0];
         bus.full_2 = p[1];
         settle("a1_others");
         chk("a1_ff_hold", {31'd0, bus.fifo_full}, 32'h1);
      end
      bus.full_1 = 1'b0;
      settle("a1_notfull");
      chk("a1_ff_low", {31'd0, bus.fifo_full}, 32'h0);
      bus.full_0 = 1'b0; bus.full_2 = 1'b0;
      // detect_add without pkt_valid leaves the address alone
      bus.pkt_valid  = 1'b0;
      bus.detect_add = 1'b1;
      bus.data_in    = 2'd2;
      tick("no_pv");
      bus.detect_add = 1'b0;
      chk("no_pv_we", {29'd0, bus.write_enb}, 32'h2);

      // 3. Address 3 steers nowhere
      latch_addr(2'd3);
      bus.full_0 = 1'b1; bus.full_1 = 1'b1; bus.full_2 = 1'b1;
      settle("a3");
      chk("a3_we", {29'd0, bus.write_enb}, 32'h0);
      chk("a3_ff", {31'd0, bus.fifo_full}, 32'h0);
      bus.full_0 = 1'b0; bus.full_1 = 1'b0; bus.full_2 = 1'b0;

      for (int a = 0; a < 3; a++) begin
         latch_addr(2'(a));
         chk("onehot_we", {29'd0, bus.write_enb}, 32'(1 << a));
      end

      // 4. Port 2 held valid and unread; write to port 2 stays active
      latch_addr(2'd2);
      clear_stats();
      bus.empty_2 = 1'b0;
      for (int i = 0; i < 65; i++) begin
         tick("p2_stall");
         if (tick_no == TMO) chk("p2_we_at_pulse", {29'd0, bus.write_enb}, 32'h4);
      end
      chk("p2_first_pulse", 32'(first_tick[2]), 32'(TMO));
      chk("p2_pulses", 32'(pulses[2]), 32'd2);
      chk("p01_quiet", 32'(pulses[0] + pulses[1]), 32'd0);
      bus.empty_2      = 1'b1;
      bus.write_en_reg = 1'b0;
      tick("p2_drain");
      tick("p2_drain");

      // 5. Port 0: a single read just before expiry restarts the count
      clear_stats();
      bus.empty_0 = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick("p0_a");
      bus.read_enb_0 = 1'b1;
      tick("p0_rd");
      bus.read_enb_0 = 1'b0;
      for (int i = 0; i < TMO - 1; i++) tick("p0_b");
      chk("p0_no_pulse", 32'(pulses[0]), 32'd0);
      tick("p0_c");
      chk("p0_pulse_30th", 32'(pulses[0]), 32'd1);
      bus.empty_0 = 1'b1;
      bus.read_enb_0 = 1'b1;
      tick("p0_drain");
      bus.read_enb_0 = 1'b0;
      tick("p0_drain");

      // 6. Port 1: asynchronous reset mid-count and mid-pulse
      latch_addr(2'd1);
      bus.write_en_reg = 1'b1;
      clear_stats();
      bus.empty_1 = 1'b0;
      for (int i = 0; i < 20; i++) tick("p1_a");
      #2;
      rst = 1'b0;
      model_reset();
      settle("p1_rst");
      chk("p1_rst_we", {29'd0, bus.write_enb}, 32'h0);
      #2;
      rst = 1'b1;
      clear_stats();
      for (int i = 0; i < TMO - 1; i++) tick("p1_b");
      chk("p1_no_early", 32'(pulses[1]), 32'd0);
      tick("p1_c");
      chk("p1_pulse", 32'(pulses[1]), 32'd1);
      #1;
      rst = 1'b0;
      model_reset();
      settle("p1_abort");
      chk("p1_abort_sr", {31'd0, bus.soft_reset_1}, 32'h0);
      #2;
      rst = 1'b1;
      bus.empty_1 = 1'b1;
      tick("end");

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
